// File: rtl/mips_mmio_pkg.sv
// Shared definitions for the MIPS memory-mapped I/O responder.
// Contents:
//   DEFAULT_BASE_ADDR   byte address of the 16-byte MMIO window
//   OFF_*               register offsets, compared against Address[3:2]
//   ST_*                bit positions inside the STATUS register
//   pack_status         assembles the STATUS read word from the four flags
package mips_mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  localparam logic [1:0] OFF_PORT_OUT = 2'd0;
  localparam logic [1:0] OFF_PORT_IN  = 2'd1;
  localparam logic [1:0] OFF_STATUS   = 2'd2;
  localparam logic [1:0] OFF_TX_DATA  = 2'd3;

  localparam int ST_IN_CHANGED = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_EMPTY      = 2;
  localparam int ST_OVERFLOW   = 3;

  // Unused STATUS bits always read back as zero.
  function automatic logic [31:0] pack_status(input logic in_changed,
                                              input logic full,
                                              input logic empty,
                                              input logic overflow);
    logic [31:0] word;
    word                = '0;
    word[ST_IN_CHANGED] = in_changed;
    word[ST_FULL]       = full;
    word[ST_EMPTY]      = empty;
    word[ST_OVERFLOW]   = overflow;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, kept generic so a later RX path can reuse it.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   push, din    write request and data; ignored when full unless popping
//   pop          read request; ignored when empty
//   dout         head entry (reads 0 while empty)
//   full, empty  derived from the occupancy count
//   count        number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);

  // Head comes straight from storage; a freshly pushed byte is visible one edge later.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder sitting beside DataMemory on the MEM-stage bus.
// Ports:
//   clk, reset            pipeline clock, asynchronous active-high reset
//   MemRead, MemWrite     MEM-stage load/store strobes
//   Address, WriteData    MEM-stage byte address and store data
//   mmio_hit              Address falls inside the 16-byte window (combinational)
//   mmio_rdata            load data, zero unless MemRead && mmio_hit (combinational)
//   PortIn                external input, asynchronous to clk
//   PortOut               software-written output register
//   tx_valid, tx_data     head of the outbound byte FIFO
//   tx_ready              consumer takes the head on this edge
// Register map (Address[3:2]): PORT_OUT, PORT_IN, STATUS (W1C), TX_DATA.
module mmio_port_responder
  import mips_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH = 4,
  parameter int          IN_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  output logic                mmio_hit,
  output logic [31:0]         mmio_rdata,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]          offset;
  logic                wr_hit;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [IN_WIDTH-1:0] in_meta;
  logic [IN_WIDTH-1:0] in_sync;
  logic [IN_WIDTH-1:0] in_prev;
  logic                in_changed;
  logic                overflow;
  logic                change_set;
  logic                overflow_set;
  logic                status_wr;
  logic                unused_addr_bits;

  // Byte lane bits are irrelevant for word-wide registers.
  assign unused_addr_bits = ^Address[1:0];

  assign mmio_hit  = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset    = Address[3:2];
  assign wr_hit    = MemWrite && mmio_hit;
  assign status_wr = wr_hit && (offset == OFF_STATUS);

  assign push     = wr_hit && (offset == OFF_TX_DATA);
  assign pop      = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut <= '0;
    end else if (wr_hit && (offset == OFF_PORT_OUT)) begin
      PortOut <= WriteData;
    end
  end

  // Two-flop synchroniser, then a one-cycle delayed copy for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_meta <= '0;
      in_sync <= '0;
      in_prev <= '0;
    end else begin
      in_meta <= PortIn;
      in_sync <= in_meta;
      in_prev <= in_sync;
    end
  end

  // Sticky flags: a new event on the same edge as a W1C clear keeps the flag set.
  assign change_set   = (in_sync != in_prev);
  assign overflow_set = push && fifo_full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_changed <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      in_changed <= change_set   || (in_changed && !(status_wr && WriteData[ST_IN_CHANGED]));
      overflow   <= overflow_set || (overflow   && !(status_wr && WriteData[ST_OVERFLOW]));
    end
  end

  // Zero-latency read path so the result lines up with RAM_DataOut.
  always_comb begin
    mmio_rdata = '0;
    if (MemRead && mmio_hit) begin
      case (offset)
        OFF_PORT_OUT: mmio_rdata = PortOut;
        OFF_PORT_IN:  mmio_rdata[IN_WIDTH-1:0] = in_sync;
        OFF_STATUS:   mmio_rdata = pack_status(in_changed, fifo_full, fifo_empty, overflow);
        default:      mmio_rdata[CW-1:0] = fifo_count;
      endcase
    end
  end

endmodule
